// File: rtl/display_bcd_driver.sv
`default_nettype none
// ============================================================================
// Module   : display_bcd_driver
// Purpose  : Serial double-dabble binary-to-BCD converter driving DIGITS
//            active-low 7-segment digits with blanking and overflow dashes.
// Revision : 1.0 - initial release
// ============================================================================
module display_bcd_driver #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 2,
    parameter int LZB    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      data,
    input  logic                  load,
    input  logic                  enable,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   segs
);

    localparam int NIB  = (WIDTH + 2) / 3 + 1;
    localparam int BCDW = 4 * NIB;
    localparam int CW   = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
    localparam logic [6:0]    c_dash = 7'b1111110;
    localparam logic [6:0]    c_off  = 7'b1111111;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [WIDTH-1:0]    r_value;
    logic [BCDW-1:0]     r_bcd;
    logic [BCDW-1:0]     w_adj;
    logic [BCDW-1:0]     w_bcd_next;
    logic [CW-1:0]       r_cnt;
    logic [4*DIGITS-1:0] r_disp;
    logic [4*DIGITS-1:0] w_digits;
    logic                r_ovf;
    logic                w_ovf;
    logic                r_done;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (load) w_state_next = S_SHIFT;
            S_SHIFT:  if (r_cnt == c_last) w_state_next = S_UPDATE;
            S_UPDATE: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = r_done;
    end

    // One double-dabble step: correct nibbles >= 5, then shift in the next MSB
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NIB; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
        w_bcd_next = {w_adj[BCDW-2:0], r_value[WIDTH-1]};
    end

    generate
        if (NIB >= DIGITS) begin : g_fit
            assign w_digits = r_bcd[4*DIGITS-1:0];
        end else begin : g_pad
            assign w_digits = {{(4*(DIGITS-NIB)){1'b0}}, r_bcd};
        end
        if (NIB > DIGITS) begin : g_ovf
            assign w_ovf = |r_bcd[BCDW-1:4*DIGITS];
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_value <= data;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_bcd   <= w_bcd_next;
                    r_value <= r_value << 1;
                    r_cnt   <= r_cnt + CW'(1);
                end
                S_UPDATE: begin
                    r_disp <= w_digits;
                    r_ovf  <= w_ovf;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ovf = r_ovf;

    // A digit is shown if blanking is off, it is digit 0, or it or any higher digit is nonzero
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            logic [3:0] w_nib;
            logic       w_show;
            assign w_nib  = r_disp[4*k +: 4];
            assign w_show = (LZB == 0) || (k == 0) || (|r_disp[4*DIGITS-1:4*k]);
            assign segs[7*k +: 7] = enable  ? c_off  :
                                    r_ovf   ? c_dash :
                                    !w_show ? c_off  : seg_decode(w_nib);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_display_bcd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_bcd_driver
// Purpose  : Directed self-checking bench for display_bcd_driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_bcd_driver;

    logic        clk;
    logic        reset;
    logic        enable;

    logic [3:0]  data4;
    logic        load4;
    logic        busy4, done4, ovf4;
    logic [13:0] segs4;

    logic [7:0]  data83;
    logic        load83;
    logic        busy83, done83, ovf83;
    logic [20:0] segs83;

    logic [7:0]  data82;
    logic        load82;
    logic        busy82, done82, ovf82;
    logic [13:0] segs82;

    int checks;
    int failures;
    int ndone;

    display_bcd_driver #(.WIDTH(4), .DIGITS(2), .LZB(1)) dut4 (
        .clk(clk), .reset(reset), .data(data4), .load(load4), .enable(enable),
        .busy(busy4), .done(done4), .ovf(ovf4), .segs(segs4)
    );

    display_bcd_driver #(.WIDTH(8), .DIGITS(3), .LZB(1)) dut83 (
        .clk(clk), .reset(reset), .data(data83), .load(load83), .enable(enable),
        .busy(busy83), .done(done83), .ovf(ovf83), .segs(segs83)
    );

    display_bcd_driver #(.WIDTH(8), .DIGITS(2), .LZB(1)) dut82 (
        .clk(clk), .reset(reset), .data(data82), .load(load82), .enable(enable),
        .busy(busy82), .done(done82), .ovf(ovf82), .segs(segs82)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        data4    = '0;  load4  = 1'b0;
        data83   = '0;  load83 = 1'b0;
        data82   = '0;  load82 = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy", {31'd0, busy4}, 32'd0);
        check("rst_done", {31'd0, done4}, 32'd0);
        check("rst_ovf",  {31'd0, ovf4},  32'd0);
        check("rst_segs4",  {18'd0, segs4},  {18'd0, 14'b1111111_0000001});
        check("rst_segs83", {11'd0, segs83}, {11'd0, 21'b1111111_1111111_0000001});

        // W4 D2: 15 -> busy for 5 cycles, done after edge 5
        data4 = 4'd15; load4 = 1'b1;
        tick();
        load4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("w4_busy_hi", {31'd0, busy4}, 32'd1);
            check("w4_no_done", {31'd0, done4}, 32'd0);
            if (i == 2) check("w4_segs_hold", {18'd0, segs4}, {18'd0, 14'b1111111_0000001});
            tick();
        end
        check("w4_busy_lo", {31'd0, busy4}, 32'd0);
        check("w4_done",    {31'd0, done4}, 32'd1);
        check("w4_segs15",  {18'd0, segs4}, {18'd0, 14'b1001111_0100100});
        check("w4_ovf",     {31'd0, ovf4},  32'd0);
        tick();
        check("w4_done_pulse", {31'd0, done4}, 32'd0);

        // W4: load held high restarts after done; data change mid-conversion ignored
        data4 = 4'd9; load4 = 1'b1;
        tick();
        data4 = 4'd3;
        repeat (5) tick();
        check("hold_done9", {31'd0, done4}, 32'd1);
        check("hold_segs9", {18'd0, segs4}, {18'd0, 14'b1111111_0000100});
        tick();
        check("hold_restart", {31'd0, busy4}, 32'd1);
        load4 = 1'b0;
        repeat (5) tick();
        check("hold_done3", {31'd0, done4}, 32'd1);
        check("hold_segs3", {18'd0, segs4}, {18'd0, 14'b1111111_0000110});

        // W8 D3: 255 then 7
        data83 = 8'd255; load83 = 1'b1;
        tick();
        load83 = 1'b0;
        repeat (9) tick();
        check("d3_done255", {31'd0, done83}, 32'd1);
        check("d3_segs255", {11'd0, segs83}, {11'd0, 21'b0010010_0100100_0100100});
        check("d3_ovf255",  {31'd0, ovf83},  32'd0);
        data83 = 8'd7; load83 = 1'b1;
        tick();
        load83 = 1'b0;
        repeat (9) tick();
        check("d3_done7", {31'd0, done83}, 32'd1);
        check("d3_segs7", {11'd0, segs83}, {11'd0, 21'b1111111_1111111_0001111});

        // W8 D2: overflow on 100, cleared by 0
        data82 = 8'd100; load82 = 1'b1;
        tick();
        load82 = 1'b0;
        repeat (9) tick();
        check("ov_ovf100",  {31'd0, ovf82},  32'd1);
        check("ov_segs100", {18'd0, segs82}, {18'd0, 14'b1111110_1111110});
        data82 = 8'd0; load82 = 1'b1;
        tick();
        load82 = 1'b0;
        repeat (9) tick();
        check("ov_ovf0",  {31'd0, ovf82},  32'd0);
        check("ov_segs0", {18'd0, segs82}, {18'd0, 14'b1111111_0000001});

        // W8 D2: load pulse during busy is ignored, exactly one done
        data82 = 8'd42; load82 = 1'b1;
        tick();
        load82 = 1'b0;
        tick();
        tick();
        load82 = 1'b1;
        tick();
        load82 = 1'b0;
        check("ign_busy", {31'd0, busy82}, 32'd1);
        ndone = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (done82) ndone++;
        end
        check("ign_one_done", ndone, 32'd1);
        check("ign_idle", {31'd0, busy82}, 32'd0);
        check("ign_segs42", {18'd0, segs82}, {18'd0, 14'b1001100_0010010});
        enable = 1'b1;
        #1;
        check("en_blank", {18'd0, segs82}, {18'd0, 14'b1111111_1111111});
        enable = 1'b0;
        #1;
        check("en_restore", {18'd0, segs82}, {18'd0, 14'b1001100_0010010});

        // W8 D3: reset on cycle 4 aborts, then 9 converts
        tick();
        data83 = 8'd200; load83 = 1'b1;
        tick();
        load83 = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy83}, 32'd0);
        check("abort_segs", {11'd0, segs83}, {11'd0, 21'b1111111_1111111_0000001});
        check("abort_ovf",  {31'd0, ovf83},  32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done83) ndone++;
            tick();
        end
        check("abort_no_done", ndone, 32'd0);
        data83 = 8'd9; load83 = 1'b1;
        tick();
        load83 = 1'b0;
        repeat (9) tick();
        check("after_done9", {31'd0, done83}, 32'd1);
        check("after_segs9", {11'd0, segs83}, {11'd0, 21'b1111111_1111111_0000100});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
